// File: rtl/cpu_pkg.sv
// Shared CPU/memory definitions: default widths, register reset values,
// memory FSM encoding and a saturating counter helper.
package cpu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 6;
  localparam int WR_COUNT_WIDTH     = 8;

  // Program placement points the loader is expected to honour.
  localparam logic [DEFAULT_ADDR_WIDTH-1:0] PC_RESET = 6'd8;
  localparam logic [DEFAULT_ADDR_WIDTH-1:0] SP_RESET = '1;

  typedef enum logic {
    MEM_INIT  = 1'b0,
    MEM_SERVE = 1'b1
  } mem_state_t;

  function automatic logic [WR_COUNT_WIDTH-1:0] sat_inc(
    input logic [WR_COUNT_WIDTH-1:0] value
  );
    if (value == '1) begin
      return value;
    end
    return value + WR_COUNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Plain storage: two write ports (caller guarantees they never collide)
// and one registered read-first port with a synchronous clear.
module mem_array
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  a_en,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_en,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  rd_clr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] storage [DEPTH];

  always_ff @(posedge clk) begin
    if (a_en) begin
      storage[a_addr] <= a_data;
    end
    if (b_en) begin
      storage[b_addr] <= b_data;
    end
  end

  // Non-blocking read alongside the writes gives read-first ordering.
  always_ff @(posedge clk) begin
    if (rd_clr) begin
      rd_data <= '0;
    end else begin
      rd_data <= storage[rd_addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// CPU-facing single-port memory: clears itself after reset, then serves
// registered reads, CPU writes and loader writes (loader wins collisions).
module mem_responder
  import cpu_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]     data,
  output logic [DATA_WIDTH-1:0]     mem,
  output logic                      busy,
  input  logic                      ld_valid,
  input  logic [ADDR_WIDTH-1:0]     ld_addr,
  input  logic [DATA_WIDTH-1:0]     ld_data,
  output logic                      ld_ready,
  output logic [WR_COUNT_WIDTH-1:0] wr_count
);

  localparam int PTR_WIDTH = ADDR_WIDTH + 1;

  // rst_n is active-high despite its name.
  logic rst;
  assign rst = rst_n;

  mem_state_t           state;
  logic [PTR_WIDTH-1:0] ptr;

  logic                  in_init;
  logic                  sweep_last;
  logic                  ld_wr_en;
  logic                  cpu_wr_en;
  logic                  a_en;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  rd_clr;

  assign in_init    = (state == MEM_INIT);
  assign sweep_last = (ptr[ADDR_WIDTH-1:0] == '1) && !ptr[ADDR_WIDTH];

  // Writes presented during a reset cycle are dropped.
  assign ld_wr_en  = !rst && !in_init && ld_valid && ld_ready;
  assign cpu_wr_en = !rst && !in_init && we && !(ld_wr_en && (ld_addr == addr));

  // Port A is shared: sweep during INIT, CPU afterwards.
  always_comb begin
    a_en   = 1'b0;
    a_addr = addr;
    a_data = data;
    if (in_init) begin
      a_en   = !rst;
      a_addr = ptr[ADDR_WIDTH-1:0];
      a_data = INIT_VALUE;
    end else begin
      a_en   = cpu_wr_en;
    end
  end

  assign rd_clr = rst || in_init;

  mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .a_en    (a_en),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .b_en    (ld_wr_en),
    .b_addr  (ld_addr),
    .b_data  (ld_data),
    .rd_clr  (rd_clr),
    .rd_addr (addr),
    .rd_data (mem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MEM_INIT;
      ptr      <= '0;
      busy     <= 1'b1;
      ld_ready <= 1'b0;
      wr_count <= '0;
    end else begin
      case (state)
        MEM_INIT: begin
          ptr <= ptr + PTR_WIDTH'(1);
          if (sweep_last) begin
            state    <= MEM_SERVE;
            busy     <= 1'b0;
            ld_ready <= 1'b1;
          end
        end
        MEM_SERVE: begin
          busy     <= 1'b0;
          ld_ready <= 1'b1;
          if (cpu_wr_en) begin
            wr_count <= sat_inc(wr_count);
          end
        end
        default: begin
          state <= MEM_INIT;
        end
      endcase
    end
  end

endmodule
